mux_lut_cell: RTL and testbench
===============================

// Module: mux_lut_cell
// PURPOSE
//  Parametrised K-input programmable logic cell built from a tree of 2:1 muxes.
//  - A 2^K-entry truth table selects any K-input boolean function (NAND, XOR, AND, ...).
//  - The table is loaded serially at run time; evaluation uses a valid/ready handshake
//    with a registered output.
//  - Generalises the fixed mux-built gates into one configurable, clocked cell.
// PARAMETERS
//  K         2     number of logic inputs; legal 1..6; table width TW = 2**K
//  INIT_TBL  0     truth table value after reset (TW bits; bit i = output for in_data==i)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  cfg_start    in   1   pulse: begin (or restart) a table load
//  cfg_bit_vld  in   1   cfg_bit is valid this cycle (sampled only in LOAD)
//  cfg_bit      in   1   serial table bit; entry 0 first, entry TW-1 last
//  cfg_done     out  1   one-cycle pulse when the last table bit is committed
//  in_valid     in   1   in_data valid
//  in_ready     out  1   cell accepts in_data this cycle
//  in_data      in   K   function inputs; in_data is the table index
//  out_valid    out  1   out_y holds an unconsumed result
//  out_ready    in   1   downstream accepts out_y
//  out_y        out  1   function result
//  busy         out  1   high while in LOAD
// BEHAVIOUR
//  Reset values: state=UNCFG; table=INIT_TBL; shadow=0; bit_cnt=0; cfg_done=0;
//   out_valid=0; out_y=0; busy=0. in_ready=0 while in reset.
//  FSM states: UNCFG, LOAD, RUN.
//   UNCFG -> LOAD   on cfg_start.
//   LOAD  -> RUN    on the cycle the TW-th bit is accepted.
//   RUN   -> LOAD   on cfg_start.
//  - If INIT_TBL != 0, reset goes directly to RUN instead of UNCFG.
//  LOAD:
//   - Each cycle with cfg_bit_vld=1 writes shadow[bit_cnt]=cfg_bit; bit_cnt++.
//   - On the last bit (bit_cnt==TW-1): table <= {cfg_bit, shadow[TW-2:0]};
//     cfg_done=1 for one cycle; bit_cnt <= 0.
//   - Partial loads never touch table.
//  cfg_start while in LOAD:
//   - Discards partial bits; bit_cnt <= 0.
//   - Any cfg_bit_vld in that same cycle is ignored.
//  in_ready = (state==RUN) && (!out_valid || out_ready).
//  Accept (in_valid && in_ready):
//   - Next cycle: out_y = table[in_data] via the mux tree; out_valid=1.
//   - Latency is 1 cycle; back-to-back throughput is 1 result/cycle while out_ready=1.
//  out_valid clears after out_valid && out_ready with no new accept in that cycle.
//  out_y holds its value while out_valid && !out_ready (stable under backpressure).
//  cfg_start while out_valid=1:
//   - The pending result is kept and still drains.
//   - New accepts are blocked until RUN is re-entered.
//  Transfers accepted before cfg_done use the old table; after cfg_done, the new one.
//  cfg_bit_vld outside LOAD is ignored.
//  Reset mid-load or mid-transfer: all state returns to reset values immediately (async).
// STRUCTURE
//  lut_pkg:
//   - state typedef (UNCFG/LOAD/RUN).
//   - localparam K_MAX=6.
//   - function tbl_w(k) = 1<<k.
//  mux_tree (param K):
//   - Purely combinational; recursive/generate tree of mux2x1 cells.
//   - Level j is selected by in_data[j]; leaves are table bits.
//   - Only sub-module.
//  Top:
//   - FSM, bit counter, shadow/table registers.
//   - One-entry output register with handshake.
// TESTING (K=2 unless noted)
//  1 Reset, no load -> in_ready=0, out_valid=0.
//    Stream 1,1,1,0 -> cfg_done pulse after 4th bit; table=4'b0111.
//    in_data=0..3 -> out_y=1,1,1,0 (NAND).
//  2 Load XOR 0,1,1,0 while in RUN.
//    - in_data=2'b01 issued before cfg_start -> y=1 (NAND).
//    - After cfg_done -> in_data 0..3 gives 0,1,1,0.
//  3 out_ready=0 for 3 cycles after in_data=3 (NAND) -> out_y=0 held, out_valid=1, in_ready=0;
//    release -> one transfer only.
//  4 cfg_start after 2 bits, then 4 bits 0,0,0,1 -> table=4'b1000 (AND), single cfg_done;
//    gaps in cfg_bit_vld tolerated.
//  5 rst_n low mid-load (bit 3) -> busy=0, table=INIT_TBL, state UNCFG.
//  6 K=3, load majority 8'b1110_1000 -> all 8 inputs match, back-to-back at 1/cycle.

Source files
------------

// File: rtl/mux_lut_cell_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_lut_cell_pkg
// Description : Shared types and helpers for the mux-tree programmable
//               logic cell: FSM state encoding, input-count limit and
//               truth-table width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_lut_cell_pkg;

  // Largest supported number of logic inputs (table of 64 entries).
  localparam int K_MAX = 6;

  // Cell operating states.
  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Truth-table width for a k-input function.
  function automatic int tbl_w(input int k);
    return 1 << k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_lut_cell_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_lut_cell_if
// Description : Configuration, input and output handshake bundle of the
//               programmable logic cell. The master side drives the table
//               stream and operands; the slave side is the cell itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_lut_cell_if #(
  parameter int K = 2
);

  logic         cfg_start;
  logic         cfg_bit_vld;
  logic         cfg_bit;
  logic         cfg_done;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_y;
  logic         busy;

  modport master (
    output cfg_start, cfg_bit_vld, cfg_bit, in_valid, in_data, out_ready,
    input  cfg_done, in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  cfg_start, cfg_bit_vld, cfg_bit, in_valid, in_data, out_ready,
    output cfg_done, in_ready, out_valid, out_y, busy
  );

endinterface
`default_nettype wire

// File: rtl/mux_lut_cell_mux_tree.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_lut_cell_mux_tree
// Description : Purely combinational binary tree of 2:1 multiplexers that
//               reads one bit of a 2**K-entry truth table. Level j halves
//               the candidate set using select bit j; the leaves are the
//               table bits themselves.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_lut_cell_mux_tree
  import mux_lut_cell_pkg::*;
#(
  parameter int K = 2
) (
  input  wire logic [tbl_w(K)-1:0] i_tbl,
  input  wire logic [K-1:0]        i_sel,
  output logic                     o_y
);

  localparam int TW = tbl_w(K);

  genvar j, i;

  for (j = 0; j < K; j++) begin : g_lvl
    localparam int NODES = TW >> (j + 1);
    logic [NODES-1:0] w_node;

    for (i = 0; i < NODES; i++) begin : g_node
      if (j == 0) begin : g_leaf
        // First level picks between adjacent table entries.
        assign w_node[i] = i_sel[0] ? i_tbl[2*i+1] : i_tbl[2*i];
      end else begin : g_inner
        // Higher levels pick between the two results of the level below.
        assign w_node[i] = i_sel[j] ? g_lvl[j-1].w_node[2*i+1]
                                    : g_lvl[j-1].w_node[2*i];
      end
    end
  end

  assign o_y = g_lvl[K-1].w_node[0];

endmodule
`default_nettype wire

// File: rtl/mux_lut_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_lut_cell
// Description : K-input programmable logic cell. A 2**K-bit truth table is
//               streamed in serially into a shadow register and committed
//               atomically on the last bit; operands are evaluated through a
//               mux tree into a one-entry registered output with a
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_lut_cell
  import mux_lut_cell_pkg::*;
#(
  parameter int                  K        = 2,
  parameter logic [(1<<K)-1:0]   INIT_TBL = '0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mux_lut_cell_if.slave bus
);

  localparam int     TW          = tbl_w(K);
  localparam state_t C_RST_STATE = (INIT_TBL != '0) ? ST_RUN : ST_UNCFG;

  if (K < 1 || K > K_MAX) begin : g_bad_k
    $error("mux_lut_cell: K must be in 1..K_MAX");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [K-1:0]    r_bit_cnt;
  logic [TW-2:0]   r_shadow;
  logic [TW-1:0]   r_table;
  logic            r_cfg_done;
  logic            r_out_valid;
  logic            r_out_y;

  logic            w_load_bit;
  logic            w_last;
  logic            w_commit;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_tree_y;

  // A restart in the same cycle as a valid bit wins; that bit is dropped.
  assign w_load_bit = (r_state == ST_LOAD) && !bus.cfg_start && bus.cfg_bit_vld;
  assign w_last     = &r_bit_cnt;
  assign w_commit   = w_load_bit && w_last;

  // Gated by rst_n so a cell that resets straight into RUN stays closed
  // while reset is still held.
  assign w_in_ready = rst_n && (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_RST_STATE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNCFG: if (bus.cfg_start) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_commit)      w_state_nxt = ST_RUN;
      ST_RUN:   if (bus.cfg_start) w_state_nxt = ST_LOAD;
      default:  w_state_nxt = C_RST_STATE;
    endcase
  end

  // Serial bit counter: cleared by any start, wraps after the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (bus.cfg_start) begin
      r_bit_cnt <= '0;
    end else if (w_load_bit) begin
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
    end
  end

  // Shadow capture of all but the final bit; the final bit goes straight
  // into the live table so the commit needs no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_load_bit && !w_last) begin
      for (int i = 0; i < TW - 1; i++) begin
        if (r_bit_cnt == K'(i)) r_shadow[i] <= bus.cfg_bit;
      end
    end
  end

  // Live truth table, only ever replaced by a complete load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_table <= INIT_TBL;
    else if (w_commit) r_table <= {bus.cfg_bit, r_shadow};
  end

  // One-cycle completion pulse, aligned with the new table becoming live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cfg_done <= 1'b0;
    else        r_cfg_done <= w_commit;
  end

  mux_lut_cell_mux_tree #(
    .K (K)
  ) u_tree (
    .i_tbl (r_table),
    .i_sel (bus.in_data),
    .o_y   (w_tree_y)
  );

  // One-entry output register: load on accept, hold under backpressure,
  // empty once consumed with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_y     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_y     <= w_tree_y;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.cfg_done  = r_cfg_done;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.busy      = (r_state == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_mux_lut_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mux_lut_cell
// Description : Directed bench for the programmable logic cell: two K=2
//               cells (one unconfigured at reset, one preset to XOR) and a
//               K=3 cell for the majority function.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_lut_cell;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_lut_cell_if #(.K(2)) b2 ();
  mux_lut_cell_if #(.K(2)) bi ();
  mux_lut_cell_if #(.K(3)) b3 ();

  mux_lut_cell #(.K(2), .INIT_TBL(4'b0000)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mux_lut_cell #(.K(2), .INIT_TBL(4'b0110)) u_duti (.clk(clk), .rst_n(rst_n), .bus(bi));
  mux_lut_cell #(.K(3), .INIT_TBL(8'h00))   u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  typedef struct {
    logic [3:0] tbl;
    logic [2:0] data;
    logic       exp_y;
  } vec_t;

  vec_t v2[12];
  vec_t v3[8];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    b2.cfg_start = 0; b2.cfg_bit_vld = 0; b2.cfg_bit = 0;
    b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 1;
    bi.cfg_start = 0; bi.cfg_bit_vld = 0; bi.cfg_bit = 0;
    bi.in_valid = 0; bi.in_data = '0; bi.out_ready = 1;
    b3.cfg_start = 0; b3.cfg_bit_vld = 0; b3.cfg_bit = 0;
    b3.in_valid = 0; b3.in_data = '0; b3.out_ready = 1;
  endtask

  // Advance to the next falling edge, tally any cfg_done seen, then drive.
  task automatic step2(input logic start, input logic vld, input logic bt);
    @(negedge clk);
    if (b2.cfg_done === 1'b1) n_done++;
    b2.cfg_start = start; b2.cfg_bit_vld = vld; b2.cfg_bit = bt;
  endtask

  task automatic load2(input logic [3:0] tbl);
    step2(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step2(0, 1, tbl[i]);
      if (i == 0) check("load busy", b2.busy, 1'b1);
      if (i == 3) check("no early done", b2.cfg_done, 1'b0);
    end
    step2(0, 0, 0);
    check("cfg_done pulse", b2.cfg_done, 1'b1);
    check("busy after load", b2.busy, 1'b0);
    step2(0, 0, 0);
    check("cfg_done one cycle", b2.cfg_done, 1'b0);
  endtask

  task automatic eval2(input vec_t v, input string name);
    @(negedge clk);
    b2.in_valid = 1; b2.in_data = v.data[1:0];
    check({name, " in_ready"}, b2.in_ready, 1'b1);
    @(negedge clk);
    b2.in_valid = 0;
    check({name, " out_valid"}, b2.out_valid, 1'b1);
    check({name, " out_y"}, b2.out_y, v.exp_y);
  endtask

  task automatic evali(input vec_t v, input string name);
    @(negedge clk);
    bi.in_valid = 1; bi.in_data = v.data[1:0];
    @(negedge clk);
    bi.in_valid = 0;
    check({name, " out_y"}, bi.out_y, v.exp_y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // NAND 4'b0111, XOR 4'b0110, AND 4'b1000; bit i is the result for input i.
    v2[0]  = '{4'b0111, 3'd0, 1'b1}; v2[1]  = '{4'b0111, 3'd1, 1'b1};
    v2[2]  = '{4'b0111, 3'd2, 1'b1}; v2[3]  = '{4'b0111, 3'd3, 1'b0};
    v2[4]  = '{4'b0110, 3'd0, 1'b0}; v2[5]  = '{4'b0110, 3'd1, 1'b1};
    v2[6]  = '{4'b0110, 3'd2, 1'b1}; v2[7]  = '{4'b0110, 3'd3, 1'b0};
    v2[8]  = '{4'b1000, 3'd0, 1'b0}; v2[9]  = '{4'b1000, 3'd1, 1'b0};
    v2[10] = '{4'b1000, 3'd2, 1'b0}; v2[11] = '{4'b1000, 3'd3, 1'b1};
    // Three-input majority.
    v3[0] = '{4'h0, 3'd0, 1'b0}; v3[1] = '{4'h0, 3'd1, 1'b0};
    v3[2] = '{4'h0, 3'd2, 1'b0}; v3[3] = '{4'h0, 3'd3, 1'b1};
    v3[4] = '{4'h0, 3'd4, 1'b0}; v3[5] = '{4'h0, 3'd5, 1'b1};
    v3[6] = '{4'h0, 3'd6, 1'b1}; v3[7] = '{4'h0, 3'd7, 1'b1};

    // ---- Reset state ----
    rst_n = 1'b0;
    drive_idle();
    #12;
    check("rst in_ready", b2.in_ready, 1'b0);
    check("rst out_valid", b2.out_valid, 1'b0);
    check("rst out_y", b2.out_y, 1'b0);
    check("rst busy", b2.busy, 1'b0);
    check("rst cfg_done", b2.cfg_done, 1'b0);
    check("rst init in_ready", bi.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("uncfg in_ready", b2.in_ready, 1'b0);
    check("init run in_ready", bi.in_ready, 1'b1);
    b2.in_valid = 1;
    @(negedge clk);
    b2.in_valid = 0;
    check("uncfg no accept", b2.out_valid, 1'b0);

    // ---- Preset XOR cell evaluates straight out of reset ----
    for (int i = 4; i < 8; i++) evali(v2[i], "init xor");

    // ---- Load NAND and evaluate ----
    load2(4'b0111);
    for (int i = 0; i < 4; i++) eval2(v2[i], "nand");

    // ---- Backpressure: result held three cycles, one transfer on release ----
    @(negedge clk);
    b2.out_ready = 0; b2.in_valid = 1; b2.in_data = 2'd3;
    check("bp accept ready", b2.in_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      b2.in_data = 2'd0;
      check("bp out_valid", b2.out_valid, 1'b1);
      check("bp out_y held", b2.out_y, 1'b0);
      check("bp in_ready", b2.in_ready, 1'b0);
    end
    b2.out_ready = 1; b2.in_valid = 0;
    @(negedge clk);
    check("bp drained", b2.out_valid, 1'b0);
    @(negedge clk);
    check("bp single xfer", b2.out_valid, 1'b0);

    // ---- Reload to XOR while a NAND result is pending ----
    // Input 0 separates the tables: NAND gives 1, XOR gives 0.
    @(negedge clk);
    b2.in_valid = 1; b2.in_data = 2'd0;
    @(negedge clk);
    b2.in_valid = 0; b2.out_ready = 0;
    check("old tbl out_y", b2.out_y, 1'b1);
    load2(4'b0110);
    check("pending kept", b2.out_valid, 1'b1);
    check("pending old y", b2.out_y, 1'b1);
    check("pending blocks", b2.in_ready, 1'b0);
    b2.out_ready = 1;
    #1;
    check("pending drains ready", b2.in_ready, 1'b1);
    @(negedge clk);
    check("pending drained", b2.out_valid, 1'b0);
    for (int i = 4; i < 8; i++) eval2(v2[i], "xor");

    // ---- Restart after two bits, gapped stream of AND ----
    n_done = 0;
    step2(1, 0, 0);
    step2(0, 1, 1);
    step2(0, 1, 1);
    step2(1, 1, 1);   // restart; this bit must be dropped
    step2(0, 1, 0);
    check("restart busy", b2.busy, 1'b1);
    step2(0, 0, 0);
    step2(0, 1, 0);
    step2(0, 1, 0);
    step2(0, 0, 1);
    step2(0, 1, 1);
    step2(0, 0, 0);
    check("restart cfg_done", b2.cfg_done, 1'b1);
    step2(0, 0, 0);
    check("single cfg_done", n_done == 1, 1'b1);
    for (int i = 8; i < 12; i++) eval2(v2[i], "and");

    // ---- Asynchronous reset in the middle of a load ----
    @(negedge clk);
    b2.cfg_start = 1; bi.cfg_start = 1;
    @(negedge clk);
    b2.cfg_start = 0; bi.cfg_start = 0;
    b2.cfg_bit_vld = 1; bi.cfg_bit_vld = 1; b2.cfg_bit = 1; bi.cfg_bit = 1;
    @(negedge clk);
    @(negedge clk);
    check("midload busy", b2.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", b2.busy, 1'b0);
    check("async rst in_ready", b2.in_ready, 1'b0);
    check("async rst out_valid", b2.out_valid, 1'b0);
    check("async rst init busy", bi.busy, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst uncfg", b2.in_ready, 1'b0);
    check("post rst busy", b2.busy, 1'b0);
    check("post rst init run", bi.in_ready, 1'b1);
    for (int i = 4; i < 8; i++) evali(v2[i], "post rst init");

    // Bits without a start are ignored outside LOAD.
    n_done = 0;
    for (int i = 0; i < 5; i++) step2(0, 1, 1);
    step2(0, 0, 0);
    check("stray bits done", n_done == 0, 1'b1);
    check("stray bits busy", b2.busy, 1'b0);
    check("stray bits uncfg", b2.in_ready, 1'b0);

    // ---- K=3 majority, back-to-back at one result per cycle ----
    @(negedge clk);
    b3.cfg_start = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b3.cfg_start = 0; b3.cfg_bit_vld = 1; b3.cfg_bit = v3[i].exp_y;
    end
    @(negedge clk);
    b3.cfg_bit_vld = 0;
    check("k3 cfg_done", b3.cfg_done, 1'b1);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("k3 b2b out_valid", b3.out_valid, 1'b1);
        check("k3 maj out_y", b3.out_y, v3[i-1].exp_y);
      end
      if (i < 8) begin
        b3.in_valid = 1; b3.in_data = v3[i].data;
        check("k3 b2b in_ready", b3.in_ready, 1'b1);
      end else begin
        b3.in_valid = 0;
      end
    end
    @(negedge clk);
    check("k3 drained", b3.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
